// File: rtl/control_suma.sv
// Keypad-driven two-operand entry controller that launches an external adder and latches its sum.
// Optional macro CLEAR_KEY_EN makes key 0xC a global clear; undefined, 0xC is ignored.
module control_suma #(
    parameter int unsigned MAX_DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [11:0] num1,
    output logic [11:0] num2,
    output logic        suma_btn,
    input  logic [12:0] resultado_in,
    output logic [12:0] resultado_out,
    output logic        result_valid,
    output logic        busy
);

    localparam int unsigned OP_W  = 12;
    localparam int unsigned RES_W = 13;
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        PULSE   = 3'd2,
        WAIT    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [OP_W-1:0]    num1_n, num2_n;
    logic [CNT_W-1:0]   cnt_a, cnt_b, cnt_a_n, cnt_b_n;
    logic [RES_W-1:0]   res_n;
    logic               valid_n, suma_n, busy_n;
    logic               is_digit, is_plus, is_eq;

    assign is_digit = key_valid && (key_code < 4'hA);
    assign is_plus  = key_valid && (key_code == 4'hA);
    assign is_eq    = key_valid && (key_code == 4'hB);

    // operand*10 + digit using shifts only
    function automatic logic [OP_W-1:0] append_digit(input logic [OP_W-1:0] op,
                                                     input logic [3:0] d);
        return (op << 3) + (op << 1) + OP_W'(d);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ENTER_A;
            num1          <= '0;
            num2          <= '0;
            cnt_a         <= '0;
            cnt_b         <= '0;
            resultado_out <= '0;
            result_valid  <= 1'b0;
            suma_btn      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            num1          <= num1_n;
            num2          <= num2_n;
            cnt_a         <= cnt_a_n;
            cnt_b         <= cnt_b_n;
            resultado_out <= res_n;
            result_valid  <= valid_n;
            suma_btn      <= suma_n;
            busy          <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        num1_n  = num1;
        num2_n  = num2;
        cnt_a_n = cnt_a;
        cnt_b_n = cnt_b;
        res_n   = resultado_out;
        valid_n = result_valid;
        suma_n  = 1'b0;

        case (state)
            ENTER_A: begin
                if (is_digit && (cnt_a < CNT_W'(MAX_DIGITS))) begin
                    num1_n  = append_digit(num1, key_code);
                    cnt_a_n = cnt_a + CNT_W'(1);
                end else if (is_plus) begin
                    state_n = ENTER_B;
                end
            end
            ENTER_B: begin
                if (is_digit && (cnt_b < CNT_W'(MAX_DIGITS))) begin
                    num2_n  = append_digit(num2, key_code);
                    cnt_b_n = cnt_b + CNT_W'(1);
                end else if (is_eq) begin
                    state_n = PULSE;
                    suma_n  = 1'b1;
                end
            end
            PULSE: state_n = WAIT;
            // adder output is valid exactly in this cycle
            WAIT: begin
                state_n = SHOW;
                res_n   = resultado_in;
                valid_n = 1'b1;
            end
            SHOW: begin
                if (is_digit) begin
                    state_n = ENTER_A;
                    num1_n  = OP_W'(key_code);
                    num2_n  = '0;
                    cnt_a_n = CNT_W'(1);
                    cnt_b_n = '0;
                    valid_n = 1'b0;
                end
            end
            default: state_n = ENTER_A;
        endcase

`ifdef CLEAR_KEY_EN
        // global clear overrides everything, including a pending capture
        if (key_valid && (key_code == 4'hC)) begin
            state_n = ENTER_A;
            num1_n  = '0;
            num2_n  = '0;
            cnt_a_n = '0;
            cnt_b_n = '0;
            res_n   = '0;
            valid_n = 1'b0;
            suma_n  = 1'b0;
        end
`endif

        busy_n = (state_n == PULSE) || (state_n == WAIT);
    end

endmodule

// File: tb/tb_control_suma.sv
// Directed self-checking bench for control_suma with a one-cycle-latency adder model.
module tb_control_suma;

    localparam logic [3:0] K_PLUS = 4'hA;
    localparam logic [3:0] K_EQ   = 4'hB;
    localparam logic [3:0] K_CLR  = 4'hC;
    localparam logic [3:0] K_D    = 4'hD;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [11:0] num1, num2;
    logic        suma_btn;
    logic [12:0] resultado_in;
    logic [12:0] resultado_out;
    logic        result_valid;
    logic        busy;

    int n_total = 0;
    int n_fail  = 0;

    control_suma #(.MAX_DIGITS(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .num1          (num1),
        .num2          (num2),
        .suma_btn      (suma_btn),
        .resultado_in  (resultado_in),
        .resultado_out (resultado_out),
        .result_valid  (result_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // adder: result valid only in the cycle after it samples suma_btn, garbage otherwise
    always @(posedge clk)
        resultado_in <= suma_btn ? (13'(num1) + 13'(num2)) : 13'h1FFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one-cycle key strobe; returns at the falling edge after it was sampled
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_num1",   32'(num1), 0);
        chk("rst_num2",   32'(num2), 0);
        chk("rst_res",    32'(resultado_out), 0);
        chk("rst_valid",  32'(result_valid), 0);
        chk("rst_suma",   32'(suma_btn), 0);
        chk("rst_busy",   32'(busy), 0);
        rst = 1'b0;

        // 123 + 456
        press(4'd1); press(4'd2); press(4'd3); press(K_PLUS);
        press(4'd4); press(4'd5); press(4'd6);
        chk("a_num1", 32'(num1), 123);
        chk("a_num2", 32'(num2), 456);
        press(K_EQ);
        chk("a_pulse",      32'(suma_btn), 1);
        chk("a_busy_pulse", 32'(busy), 1);
        @(negedge clk);
        chk("a_pulse_off",  32'(suma_btn), 0);
        chk("a_busy_wait",  32'(busy), 1);
        chk("a_valid_wait", 32'(result_valid), 0);
        chk("a_num1_stable", 32'(num1), 123);
        @(negedge clk);
        chk("a_res",   32'(resultado_out), 579);
        chk("a_valid", 32'(result_valid), 1);
        chk("a_busy_show", 32'(busy), 0);
        chk("a_num2_hold", 32'(num2), 456);

        // 9999 + 9999: fourth digits dropped
        press(4'd9);
        chk("b_valid_clr", 32'(result_valid), 0);
        chk("b_num2_clr",  32'(num2), 0);
        chk("b_num1_first", 32'(num1), 9);
        press(4'd9); press(4'd9); press(4'd9);
        chk("b_num1", 32'(num1), 999);
        press(K_PLUS);
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        chk("b_num2", 32'(num2), 999);
        press(K_EQ);
        repeat (2) @(negedge clk);
        chk("b_res",   32'(resultado_out), 1998);
        chk("b_valid", 32'(result_valid), 1);

        // '=' in ENTER_A ignored; empty B yields 5 + 0
        press(4'd5);
        press(K_EQ);
        chk("c_no_pulse", 32'(suma_btn), 0);
        chk("c_no_busy",  32'(busy), 0);
        @(negedge clk);
        chk("c_no_pulse2", 32'(suma_btn), 0);
        press(K_PLUS);
        press(K_PLUS);
        press(K_EQ);
        chk("c_pulse", 32'(suma_btn), 1);
        repeat (2) @(negedge clk);
        chk("c_res",   32'(resultado_out), 5);
        chk("c_num2",  32'(num2), 0);

        // keys during PULSE/WAIT ignored
        press(4'd1); press(K_PLUS); press(4'd2); press(K_EQ);
        key_valid = 1'b1; key_code = 4'd7;
        @(negedge clk);
        key_code = 4'd3;
        @(negedge clk);
        key_valid = 1'b0; key_code = 4'h0;
        chk("d_res",   32'(resultado_out), 3);
        chk("d_valid", 32'(result_valid), 1);
        chk("d_num1",  32'(num1), 1);
        chk("d_num2",  32'(num2), 2);
        press(4'd8);
        chk("d_valid_clr", 32'(result_valid), 0);
        chk("d_num1_8",    32'(num1), 8);
        press(4'd1);
        chk("d_enter_a",   32'(num1), 81);

        // reset in WAIT aborts the capture
        press(K_PLUS); press(4'd1); press(K_EQ);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("e_res",   32'(resultado_out), 0);
        chk("e_valid", 32'(result_valid), 0);
        chk("e_busy",  32'(busy), 0);
        chk("e_num1",  32'(num1), 0);
        chk("e_suma",  32'(suma_btn), 0);

        // leading zeros count as digits; 0xD ignored
        press(4'd0); press(4'd0); press(4'd5); press(4'd7);
        chk("f_num1", 32'(num1), 5);
        press(K_D);
        chk("f_num1_d", 32'(num1), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // clear key
        press(4'd4); press(4'd2); press(K_PLUS); press(K_CLR);
`ifdef CLEAR_KEY_EN
        chk("g_num1", 32'(num1), 0);
        chk("g_num2", 32'(num2), 0);
        press(4'd7);
        chk("g_enter_a", 32'(num1), 7);
        chk("g_num2_b",  32'(num2), 0);
`else
        chk("g_num1", 32'(num1), 42);
        chk("g_num2", 32'(num2), 0);
        press(4'd7);
        chk("g_enter_b", 32'(num2), 7);
        chk("g_num1_b",  32'(num1), 42);
`endif

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
